// File: rtl/square64.sv
// Iterative squarer: sq = a*a, one operand bit per clock, rdy exactly W clocks after an accepted start.
// Optional root self-check (x_ref in, ok out) is built when SQUARE64_CHECK_EN is defined.
module square64 #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
`ifdef SQUARE64_CHECK_EN
  input  logic [2*W-1:0] x_ref,
  output logic           ok,
`endif
  output logic           busy,
  output logic           rdy,
  output logic [2*W-1:0] sq
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = IW + 1;
  localparam logic [2*W-1:0] ONE2 = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic           accept;
  logic [W-1:0]   a_q;
  logic [W-1:0]   acc, acc_nxt;
  logic [2*W-1:0] acc2, acc2_nxt;
  logic [CW-1:0]  bitl;
  logic [IW-1:0]  idx;
  logic           last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = RUN;
        accept    = 1'b1;
      end
      RUN: if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign rdy  = (state == DONE);
  assign idx  = bitl[IW-1:0];
  assign last = (bitl == '0);

  // (acc + 2^b)^2 = acc2 + 2*acc*2^b + 2^(2b)
  always_comb begin
    acc_nxt  = acc;
    acc2_nxt = acc2;
    if (a_q[idx]) begin
      acc_nxt  = acc | (W'(1) << idx);
      acc2_nxt = acc2 + (ONE2 << (2 * idx)) + (({{W{1'b0}}, acc} << idx) << 1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      acc  <= '0;
      acc2 <= '0;
      bitl <= '0;
      sq   <= '0;
    end else if (accept) begin
      a_q  <= a;
      acc  <= '0;
      acc2 <= '0;
      bitl <= CW'(W - 1);
    end else if (state == RUN) begin
      acc  <= acc_nxt;
      acc2 <= acc2_nxt;
      if (last) sq <= acc2_nxt;
      else      bitl <= bitl - 1'b1;
    end
  end

`ifdef SQUARE64_CHECK_EN
  localparam logic [2*W:0] ONEX = 1;
  logic [2*W-1:0] x_ref_q;
  logic [2*W:0]   upper;

  // Next square above sq, widened by one bit so a = 2^W-1 cannot wrap.
  assign upper = {1'b0, acc2_nxt} + {{W{1'b0}}, a_q, 1'b0} + ONEX;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_ref_q <= '0;
      ok      <= 1'b0;
    end else if (accept) begin
      x_ref_q <= x_ref;
      ok      <= 1'b0;
    end else if (state == RUN && last) begin
      ok <= (acc2_nxt <= x_ref_q) && ({1'b0, x_ref_q} < upper);
    end
  end
`endif

endmodule
